// File: rtl/sort_batch_ctrl.sv
// Batch controller around an external N-lane sorter: fills lanes, waits out the sorter, drains results.
// Optional macro DRAIN_TOPK_EN limits each batch's output to the TOP_K smallest entries.
module sort_batch_ctrl #(
    parameter int unsigned DW       = 8,
    parameter int unsigned IW       = 8,
    parameter int unsigned N        = 16,
    parameter int unsigned SORT_LAT = 2,
    parameter int unsigned TOP_K    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_dist,
    input  logic [IW-1:0]   in_id,
    input  logic            in_last,
    output logic [N*DW-1:0] srt_dist,
    output logic [N*IW-1:0] srt_id,
    input  logic [N*DW-1:0] srt_res_dist,
    input  logic [N*IW-1:0] srt_res_id,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_dist,
    output logic [IW-1:0]   out_id,
    output logic            out_last,
    output logic            busy
);

    localparam int unsigned CW = $clog2(N + 1);
    localparam int unsigned XW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned SW = $clog2(SORT_LAT + 2);

`ifdef DRAIN_TOPK_EN
    localparam int unsigned LIMIT = (TOP_K < N) ? TOP_K : N;
`else
    localparam int unsigned LIMIT = N;
    logic unused_topk;
    assign unused_topk = ^TOP_K;
`endif

    typedef enum logic [1:0] {StFill, StSort, StDrain} state_e;

    state_e         state_q;
    logic [CW-1:0]  cnt_q;
    logic [XW-1:0]  idx_q;
    logic [SW-1:0]  sort_cnt_q;
    logic [DW-1:0]  lane_dist_q [N];
    logic [IW-1:0]  lane_id_q   [N];
    logic [DW-1:0]  res_dist_q  [N];
    logic [IW-1:0]  res_id_q    [N];

    logic [CW-1:0]  num_out;
    logic [XW-1:0]  last_idx;
    logic [XW-1:0]  idx_nxt;

    always_comb begin
        num_out  = (cnt_q > CW'(LIMIT)) ? CW'(LIMIT) : cnt_q;
        last_idx = XW'(num_out - CW'(1));
        idx_nxt  = idx_q + XW'(1);
    end

    for (genvar g = 0; g < N; g++) begin : g_lanes
        assign srt_dist[g*DW +: DW] = lane_dist_q[g];
        assign srt_id[g*IW +: IW]   = lane_id_q[g];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StFill;
            cnt_q      <= '0;
            idx_q      <= '0;
            sort_cnt_q <= '0;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_dist   <= '0;
            out_id     <= '0;
            for (int i = 0; i < N; i++) begin
                lane_dist_q[i] <= '1;
                lane_id_q[i]   <= '0;
            end
        end else begin
            unique case (state_q)
                StFill: begin
                    if (in_valid && in_ready) begin
                        lane_dist_q[cnt_q[XW-1:0]] <= in_dist;
                        lane_id_q[cnt_q[XW-1:0]]   <= in_id;
                        cnt_q <= cnt_q + CW'(1);
                        busy  <= 1'b1;
                        if (in_last || cnt_q == CW'(N - 1)) begin
                            state_q    <= StSort;
                            in_ready   <= 1'b0;
                            sort_cnt_q <= '0;
                        end
                    end
                end
                StSort: begin
                    // Lanes stay frozen here so the sorter sees a stable bus for SORT_LAT+1 cycles.
                    if (sort_cnt_q == SW'(SORT_LAT)) begin
                        for (int i = 0; i < N; i++) begin
                            res_dist_q[i] <= srt_res_dist[i*DW +: DW];
                            res_id_q[i]   <= srt_res_id[i*IW +: IW];
                        end
                        out_valid  <= 1'b1;
                        out_dist   <= srt_res_dist[DW-1:0];
                        out_id     <= srt_res_id[IW-1:0];
                        out_last   <= (num_out == CW'(1));
                        idx_q      <= '0;
                        sort_cnt_q <= '0;
                        state_q    <= StDrain;
                    end else begin
                        sort_cnt_q <= sort_cnt_q + SW'(1);
                    end
                end
                StDrain: begin
                    if (out_ready) begin
                        if (idx_q == last_idx) begin
                            state_q   <= StFill;
                            cnt_q     <= '0;
                            idx_q     <= '0;
                            in_ready  <= 1'b1;
                            busy      <= 1'b0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_dist  <= '0;
                            out_id    <= '0;
                            for (int i = 0; i < N; i++) begin
                                lane_dist_q[i] <= '1;
                                lane_id_q[i]   <= '0;
                            end
                        end else begin
                            idx_q    <= idx_nxt;
                            out_dist <= res_dist_q[idx_nxt];
                            out_id   <= res_id_q[idx_nxt];
                            out_last <= (idx_nxt == last_idx);
                        end
                    end
                end
                default: state_q <= StFill;
            endcase
        end
    end

endmodule

// File: tb/tb_sort_batch_ctrl.sv
// Bench for sort_batch_ctrl: behavioural sorter with SORT_LAT pipeline and a selection-based reference.
module tb_sort_batch_ctrl;

    localparam int DW       = 8;
    localparam int IW       = 8;
    localparam int N        = 16;
    localparam int SORT_LAT = 2;
    localparam int TOP_K    = 4;
`ifdef DRAIN_TOPK_EN
    localparam int LIMIT = TOP_K;
`else
    localparam int LIMIT = N;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid, in_ready, in_last;
    logic [DW-1:0]   in_dist;
    logic [IW-1:0]   in_id;
    logic [N*DW-1:0] srt_dist, srt_res_dist;
    logic [N*IW-1:0] srt_id, srt_res_id;
    logic            out_valid, out_ready, out_last, busy;
    logic [DW-1:0]   out_dist;
    logic [IW-1:0]   out_id;

    int ncmp = 0;
    int nfail = 0;
    int cyc = 0;
    int bd[N];
    int bi[N];
    int qd[$], qi[$], ed[$], ei[$];

    always #5 clk = ~clk;

    sort_batch_ctrl #(
        .DW(DW), .IW(IW), .N(N), .SORT_LAT(SORT_LAT), .TOP_K(TOP_K)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_dist(in_dist), .in_id(in_id),
        .in_last(in_last),
        .srt_dist(srt_dist), .srt_id(srt_id),
        .srt_res_dist(srt_res_dist), .srt_res_id(srt_res_id),
        .out_valid(out_valid), .out_ready(out_ready), .out_dist(out_dist), .out_id(out_id),
        .out_last(out_last), .busy(busy)
    );

    // Stable ascending sorter with SORT_LAT register stages.
    function automatic logic [N*(DW+IW)-1:0] sorter(input logic [N*DW-1:0] d,
                                                    input logic [N*IW-1:0] id);
        logic [DW-1:0] a[N];
        logic [IW-1:0] b[N];
        logic [DW-1:0] kd;
        logic [IW-1:0] ki;
        logic [N*(DW+IW)-1:0] r;
        int j;
        for (int i = 0; i < N; i++) begin
            a[i] = d[i*DW +: DW];
            b[i] = id[i*IW +: IW];
        end
        for (int i = 1; i < N; i++) begin
            kd = a[i];
            ki = b[i];
            j = i - 1;
            while (j >= 0 && a[j] > kd) begin
                a[j+1] = a[j];
                b[j+1] = b[j];
                j--;
            end
            a[j+1] = kd;
            b[j+1] = ki;
        end
        for (int i = 0; i < N; i++) begin
            r[i*DW +: DW]          = a[i];
            r[N*DW + i*IW +: IW]   = b[i];
        end
        return r;
    endfunction

    logic [N*(DW+IW)-1:0] pipe [SORT_LAT];
    always @(posedge clk) begin
        pipe[0] <= sorter(srt_dist, srt_id);
        for (int s = 1; s < SORT_LAT; s++) pipe[s] <= pipe[s-1];
    end
    assign srt_res_dist = pipe[SORT_LAT-1][N*DW-1:0];
    assign srt_res_id   = pipe[SORT_LAT-1][N*(DW+IW)-1:N*DW];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_lanes_padded(input string tag);
        ncmp++;
        assert (srt_dist === {N*DW{1'b1}} && srt_id === {N*IW{1'b0}}) else begin
            nfail++;
            $error("FAIL %s: observed dist %h id %h expected all-ones / zero", tag, srt_dist, srt_id);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Reference: repeatedly pick the earliest minimum, up to min(count, LIMIT) entries.
    task automatic build_expect();
        int td[$];
        int ti[$];
        int m;
        int lim;
        td = qd;
        ti = qi;
        ed.delete();
        ei.delete();
        lim = (qd.size() < LIMIT) ? qd.size() : LIMIT;
        for (int k = 0; k < lim; k++) begin
            m = 0;
            for (int j = 1; j < td.size(); j++) if (td[j] < td[m]) m = j;
            ed.push_back(td[m]);
            ei.push_back(ti[m]);
            td.delete(m);
            ti.delete(m);
        end
    endtask

    task automatic push_one(input int d, input int id, input logic last);
        int w;
        in_valid = 1'b1;
        in_dist  = DW'(d);
        in_id    = IW'(id);
        in_last  = last;
        w = 0;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // rmode: 0 always ready, 1 pattern 1,0,0,1, 2 random ready.
    task automatic run_batch(input int n, input int gap, input int rmode);
        int acc, first, k, guard, ptr;
        logic lst;
        qd.delete();
        qi.delete();
        for (int i = 0; i < n; i++) begin
            qd.push_back(bd[i]);
            qi.push_back(bi[i]);
        end
        build_expect();
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, gap)) begin
                in_last = 1'($urandom_range(0, 1));
                tick();
            end
            in_last = 1'b0;
            lst = (i == n - 1) && (n < N || $urandom_range(0, 1) == 1);
            push_one(bd[i], bi[i], lst);
            if (i == 0) chk("busy_after_accept", {31'd0, busy}, 32'd1);
        end
        chk("in_ready_in_sort", {31'd0, in_ready}, 32'd0);
        acc = cyc;
        first = -1;
        k = 0;
        guard = 0;
        ptr = 0;
        while (k < ed.size() && guard < 300) begin
            if (out_valid) begin
                if (first < 0) first = cyc;
                case (rmode)
                    0: out_ready = 1'b1;
                    1: out_ready = (ptr % 4 == 0) || (ptr % 4 == 3);
                    default: out_ready = 1'($urandom_range(0, 1));
                endcase
                ptr++;
                chk("out_dist", {24'd0, out_dist}, 32'(ed[k]));
                chk("out_id", {24'd0, out_id}, 32'(ei[k]));
                chk("out_last", {31'd0, out_last}, (k == ed.size() - 1) ? 32'd1 : 32'd0);
                if (out_ready) k++;
            end else if (first >= 0) begin
                chk("out_valid_mid_batch", {31'd0, out_valid}, 32'd1);
            end
            tick();
            guard++;
        end
        out_ready = 1'b0;
        chk("results_drained", 32'(k), 32'(ed.size()));
        chk("first_valid_latency", 32'(first - acc), 32'(SORT_LAT + 1));
        chk("out_valid_after_last", {31'd0, out_valid}, 32'd0);
        chk("in_ready_after_drain", {31'd0, in_ready}, 32'd1);
        chk("busy_after_drain", {31'd0, busy}, 32'd0);
        chk_lanes_padded("lanes_after_drain");
        tick();
        tick();
        chk("no_padding_output", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        rst = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        in_dist = '0;
        in_id = '0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_dist", {24'd0, out_dist}, 32'd0);
        chk("rst_out_id", {24'd0, out_id}, 32'd0);
        chk_lanes_padded("rst_lanes");
        rst = 1'b0;
        tick();

        // Full batch, descending distances, closed by count.
        for (int i = 0; i < N; i++) begin
            bd[i] = 15 - i;
            bi[i] = i;
        end
        run_batch(N, 0, 0);

        // Partial batch closed by in_last.
        bd[0] = 9; bd[1] = 3; bd[2] = 7;
        bi[0] = 1; bi[1] = 2; bi[2] = 3;
        run_batch(3, 2, 0);

        // Ties keep input order.
        bd[0] = 5; bd[1] = 5;
        bi[0] = 8'hA; bi[1] = 8'hB;
        run_batch(2, 0, 0);

        // Backpressure 1,0,0,1.
        for (int i = 0; i < 6; i++) begin
            bd[i] = $urandom_range(0, 255);
            bi[i] = $urandom_range(0, 255);
        end
        run_batch(6, 1, 1);

        // Full batch of 16*k mod 256 (exercises TOP_K when enabled).
        for (int i = 0; i < N; i++) begin
            bd[i] = (16 * (N - 1 - i)) % 256;
            bi[i] = i + 32;
        end
        run_batch(N, 0, 0);

        // Reset during the second DRAIN cycle discards the batch.
        bd[0] = 4; bd[1] = 8; bd[2] = 2;
        push_one(4, 1, 1'b0);
        push_one(8, 2, 1'b0);
        push_one(2, 3, 1'b1);
        w = 0;
        while (!out_valid && w < 20) begin
            tick();
            w++;
        end
        chk("mid_drain_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b0;
        chk("rst_drain_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_drain_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_drain_busy", {31'd0, busy}, 32'd0);
        chk_lanes_padded("rst_drain_lanes");
        tick();
        tick();
        chk("rst_drain_silent", {31'd0, out_valid}, 32'd0);
        bd[0] = 1;
        bi[0] = 7;
        run_batch(1, 0, 0);

        // Random batches, including ties and 0xFF distances.
        for (int b = 0; b < 12; b++) begin
            int n;
            n = $urandom_range(1, N);
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 2))
                    0: bd[i] = $urandom_range(0, 7);
                    1: bd[i] = 255;
                    default: bd[i] = $urandom_range(0, 255);
                endcase
                bi[i] = $urandom_range(0, 255);
            end
            run_batch(n, 2, 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
